// File: rtl/pixel_writer.sv
// Pixel writer: converts traced fp24 RGB results to RGB565, computes the framebuffer
// address and queues writes through a small first-word-fall-through FIFO.
module pixel_writer #(
    parameter int unsigned WIDTH      = 1280,
    parameter int unsigned HEIGHT     = 720,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ray_done,
    input  logic [71:0] pixel_color,
    input  logic [10:0] pixel_h,
    input  logic [9:0]  pixel_v,
    output logic        in_ready,
    output logic [19:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned SumW = CntW + 2;
    localparam logic [19:0] LastAddr = 20'(WIDTH * HEIGHT - 1);

    // fp24: sign[23], exp[22:16] bias 63, mant[15:0]; maps [0,1) onto 0..255 by truncation
    function automatic logic [7:0] fp24_to_u8(input logic [23:0] w);
        logic [6:0]  e;
        logic [16:0] m;
        logic [16:0] sh;
        e = w[22:16];
        m = {1'b1, w[15:0]};
        if (w[23] || (e < 7'd55) || (w == 24'd0)) begin
            return 8'd0;
        end else if (e >= 7'd63) begin
            return 8'd255;
        end else begin
            sh = m >> (7'd71 - e);
            return sh[7:0];
        end
    endfunction

    // Stage S1 registers
    logic        s1_valid_q;
    logic [71:0] s1_color_q;
    logic [10:0] s1_h_q;
    logic [9:0]  s1_v_q;

    // Stage S2 registers
    logic        s2_valid_q, s2_valid_d;
    logic [19:0] s2_addr_q, s2_addr_d;
    logic [15:0] s2_data_q, s2_data_d;

    // FIFO state
    logic [35:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic        frame_done_q;
    logic [15:0] frame_count_q;
    logic        overflow_q;

    logic        full, push, pop;
    logic [35:0] head;
    logic [SumW-1:0] occ_sum;
    logic [7:0]  r8, g8, b8;

    // S1 captures every pulse; flow control is advisory via in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_color_q <= '0;
            s1_h_q     <= '0;
            s1_v_q     <= '0;
        end else begin
            s1_valid_q <= ray_done;
            if (ray_done) begin
                s1_color_q <= pixel_color;
                s1_h_q     <= pixel_h;
                s1_v_q     <= pixel_v;
            end
        end
    end

    // S2 next state: colour conversion, address and off-screen filtering
    always_comb begin
        r8         = fp24_to_u8(s1_color_q[71:48]);
        g8         = fp24_to_u8(s1_color_q[47:24]);
        b8         = fp24_to_u8(s1_color_q[23:0]);
        s2_data_d  = {r8[7:3], g8[7:2], b8[7:3]};
        s2_addr_d  = 20'(s1_v_q) * 20'(WIDTH) + 20'(s1_h_q);
        s2_valid_d = s1_valid_q && (32'(s1_h_q) < WIDTH) && (32'(s1_v_q) < HEIGHT);
    end

    // S2 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
        end
    end

    // FIFO handshake and output view; a pop at full frees the slot for a same-edge push
    always_comb begin
        full     = (count_q == CntW'(FIFO_DEPTH));
        fb_valid = (count_q != '0);
        pop      = fb_valid && fb_ready;
        push     = s2_valid_q && (!full || pop);
        head     = mem_q[rd_ptr_q];
        fb_addr  = fb_valid ? head[35:16] : 20'd0;
        fb_data  = fb_valid ? head[15:0] : 16'd0;
        occ_sum  = SumW'(count_q) + SumW'(s1_valid_q) + SumW'(s2_valid_q);
        in_ready = (occ_sum < SumW'(FIFO_DEPTH));
    end

    // FIFO storage; contents are don't-care until pointed to by a valid count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s2_addr_q, s2_data_q};
        end
    end

    // FIFO pointers, occupancy, frame tracking and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (s2_valid_q && !push) overflow_q <= 1'b1;
            frame_done_q <= pop && (head[35:16] == LastAddr);
            if (pop && (head[35:16] == LastAddr)) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: stimulus pushes expected writes, a negedge monitor
// pops and compares on every framebuffer handshake.
module tb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ray_done;
    logic [71:0] pixel_color;
    logic [10:0] pixel_h;
    logic [9:0]  pixel_v;
    logic        in_ready;
    logic [19:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_valid;
    logic        fb_ready;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        overflow;

    typedef struct packed {
        logic [19:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_writes = 0;
    int   n_frame_done = 0;
    int   wr_before;

    always #5 clk = ~clk;

    pixel_writer #(
        .WIDTH(1280),
        .HEIGHT(720),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ray_done(ray_done),
        .pixel_color(pixel_color),
        .pixel_h(pixel_h),
        .pixel_v(pixel_v),
        .in_ready(in_ready),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .fb_valid(fb_valid),
        .fb_ready(fb_ready),
        .frame_done(frame_done),
        .frame_count(frame_count),
        .overflow(overflow)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: compare each accepted write against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && frame_done) n_frame_done++;
        if (rst_n && fb_valid && fb_ready) begin
            n_writes++;
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         fb_addr, fb_data);
            end else begin
                e = expq.pop_front();
                check("wr_addr", 32'(fb_addr), 32'(e.a));
                check("wr_data", 32'(fb_data), 32'(e.d));
            end
        end
    end

    // Present one result; caller is at posedge+1
    task automatic drive(input logic [71:0] c, input logic [10:0] h, input logic [9:0] v);
        ray_done    = 1'b1;
        pixel_color = c;
        pixel_h     = h;
        pixel_v     = v;
    endtask

    task automatic pulse(input logic [71:0] c, input logic [10:0] h, input logic [9:0] v,
                         input bit exp_wr, input logic [19:0] a, input logic [15:0] d);
        drive(c, h, v);
        if (exp_wr) expq.push_back('{a: a, d: d});
        @(posedge clk);
        #1;
        ray_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        ray_done    = 1'b0;
        pixel_color = '0;
        pixel_h     = '0;
        pixel_v     = '0;
        fb_ready    = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_fb_valid", 32'(fb_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_data", 32'(fb_data), 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // White pixel: latency and address
        drive({3{24'h3F0000}}, 11'd5, 10'd2);
        expq.push_back('{a: 20'h00A05, d: 16'hFFFF});
        wr_before = n_writes;
        @(posedge clk);
        #1;
        ray_done = 1'b0;
        check("lat_after_k", 32'(fb_valid), 0);
        @(posedge clk);
        #1;
        check("lat_after_k1", 32'(fb_valid), 0);
        @(posedge clk);
        #1;
        check("lat_after_k2", 32'(fb_valid), 1);
        check("lat_addr", 32'(fb_addr), 32'h00A05);
        check("lat_data", 32'(fb_data), 32'hFFFF);
        idle(5);
        check("white_writes", 32'(n_writes - wr_before), 1);

        // Half-intensity grey
        wr_before = n_writes;
        pulse({3{24'h3E0000}}, 11'd10, 10'd0, 1'b1, 20'd10, 16'h8410);
        idle(6);
        check("grey_writes", 32'(n_writes - wr_before), 1);

        // Negative, smallest nonzero, saturating channels
        wr_before = n_writes;
        pulse({24'hBF0000, 24'h370000, 24'h400000}, 11'd0, 10'd1, 1'b1, 20'd1280, 16'h001F);
        idle(6);
        check("mixed_writes", 32'(n_writes - wr_before), 1);

        // Last pixel of the frame, then an off-screen result
        n_frame_done = 0;
        check("pre_frame_count", 32'(frame_count), 0);
        wr_before = n_writes;
        pulse({3{24'h3F0000}}, 11'd1279, 10'd719, 1'b1, 20'hE0FFF, 16'hFFFF);
        idle(6);
        check("frame_writes", 32'(n_writes - wr_before), 1);
        check("frame_done_pulses", 32'(n_frame_done), 1);
        check("frame_count_inc", 32'(frame_count), 1);
        wr_before = n_writes;
        pulse({3{24'h3F0000}}, 11'd1280, 10'd0, 1'b0, 20'd0, 16'd0);
        idle(6);
        check("offscreen_writes", 32'(n_writes - wr_before), 0);
        check("offscreen_overflow", 32'(overflow), 0);
        check("offscreen_frame_count", 32'(frame_count), 1);

        // Back-pressure: six results into a four-entry path
        fb_ready  = 1'b0;
        wr_before = n_writes;
        for (int i = 0; i < 6; i++) begin
            drive({3{24'h3E0000}}, 11'(i), 10'd0);
            if (i < 4) expq.push_back('{a: 20'(i), d: 16'h8410});
            @(posedge clk);
            #1;
            check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), (i < 3) ? 1 : 0);
        end
        ray_done = 1'b0;
        idle(4);
        check("bp_overflow", 32'(overflow), 1);
        check("bp_valid", 32'(fb_valid), 1);
        check("bp_hold_addr", 32'(fb_addr), 0);
        idle(2);
        check("bp_hold_addr2", 32'(fb_addr), 0);
        check("bp_hold_data", 32'(fb_data), 32'h8410);
        fb_ready = 1'b1;
        idle(8);
        check("bp_writes", 32'(n_writes - wr_before), 4);
        check("bp_queue_empty", 32'(expq.size()), 0);

        // Reset with two pending entries
        fb_ready = 1'b0;
        pulse({3{24'h3F0000}}, 11'd1, 10'd1, 1'b1, 20'd1281, 16'hFFFF);
        pulse({3{24'h3F0000}}, 11'd2, 10'd1, 1'b1, 20'd1282, 16'hFFFF);
        idle(3);
        check("pre_rst_valid", 32'(fb_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(fb_valid), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_frame_count", 32'(frame_count), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        expq.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        fb_ready  = 1'b1;
        wr_before = n_writes;
        idle(10);
        check("post_rst_writes", 32'(n_writes - wr_before), 0);
        check("post_rst_valid", 32'(fb_valid), 0);
        check("post_rst_frame_count", 32'(frame_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
